light_sequencer: RTL

Timed traffic-light state machine that produces the 2-bit light selection consumed by the downstream LED colour/mask stage. It cycles RED → GREEN → YELLOW with per-phase durations in milliseconds. It latches a debounced pedestrian request, which shortens GREEN (after a minimum) and inserts a WALK phase after YELLOW. It sits between the input debouncer and the light output stage.

---
 rtl/light_sequencer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/light_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : light_sequencer
// Brief    : Timed RED/GREEN/YELLOW traffic-light FSM with a latched pedestrian
//            request that shortens GREEN and inserts a WALK phase.
// Revision : 1.0 - initial release
// ============================================================================
module light_sequencer #(
    parameter int C_CLK_FRQ      = 100000000,
    parameter int C_RED_MS       = 4000,
    parameter int C_GREEN_MS     = 5000,
    parameter int C_YELLOW_MS    = 1000,
    parameter int C_WALK_MS      = 3000,
    parameter int C_MIN_GREEN_MS = 2000
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic       inPedestrian,
    output logic [1:0] outSel,
    output logic       outPedAck
);

    localparam int c_presc      = C_CLK_FRQ / 1000;
    localparam int c_max_ab     = (C_RED_MS > C_GREEN_MS) ? C_RED_MS : C_GREEN_MS;
    localparam int c_max_cd     = (C_YELLOW_MS > C_WALK_MS) ? C_YELLOW_MS : C_WALK_MS;
    localparam int c_max_ms     = (c_max_ab > c_max_cd) ? c_max_ab : c_max_cd;
    localparam int c_presc_w    = (c_presc > 1) ? $clog2(c_presc) : 1;
    localparam int c_ms_w       = (c_max_ms > 1) ? $clog2(c_max_ms) : 1;

    localparam logic [c_presc_w-1:0] c_presc_last   = c_presc_w'(c_presc - 1);
    localparam logic [c_ms_w-1:0]    c_red_last     = c_ms_w'(C_RED_MS - 1);
    localparam logic [c_ms_w-1:0]    c_green_last   = c_ms_w'(C_GREEN_MS - 1);
    localparam logic [c_ms_w-1:0]    c_yellow_last  = c_ms_w'(C_YELLOW_MS - 1);
    localparam logic [c_ms_w-1:0]    c_walk_last    = c_ms_w'(C_WALK_MS - 1);
    localparam logic [c_ms_w-1:0]    c_min_grn_last = c_ms_w'(C_MIN_GREEN_MS - 1);

    typedef enum logic [1:0] {
        S_RED    = 2'b00,
        S_GREEN  = 2'b01,
        S_YELLOW = 2'b10,
        S_WALK   = 2'b11
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 w_exit;
    logic                 w_tick;
    logic                 w_rise;
    logic [c_presc_w-1:0] r_prescale;
    logic [c_ms_w-1:0]    r_ms_count;
    logic                 r_pending;
    logic                 r_ped_q;

    assign w_tick    = (r_prescale == c_presc_last);
    assign w_rise    = inPedestrian & ~r_ped_q;
    assign outSel    = r_state;
    assign outPedAck = r_pending;

    always_comb begin
        w_next = r_state;
        w_exit = 1'b0;
        if (w_tick) begin
            case (r_state)
                S_RED: begin
                    if (r_ms_count == c_red_last) begin
                        w_next = S_GREEN;
                        w_exit = 1'b1;
                    end
                end
                S_GREEN: begin
                    // A pending request cuts GREEN once the minimum has elapsed.
                    if ((r_ms_count == c_green_last) ||
                        (r_pending && (r_ms_count >= c_min_grn_last))) begin
                        w_next = S_YELLOW;
                        w_exit = 1'b1;
                    end
                end
                S_YELLOW: begin
                    if (r_ms_count == c_yellow_last) begin
                        w_next = r_pending ? S_WALK : S_RED;
                        w_exit = 1'b1;
                    end
                end
                S_WALK: begin
                    if (r_ms_count == c_walk_last) begin
                        w_next = S_RED;
                        w_exit = 1'b1;
                    end
                end
                default: begin
                    w_next = S_RED;
                    w_exit = 1'b1;
                end
            endcase
        end
    end

    // Edge register resets high so a button held through reset is not a request.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state    <= S_RED;
            r_prescale <= '0;
            r_ms_count <= '0;
            r_pending  <= 1'b0;
            r_ped_q    <= 1'b1;
        end else begin
            r_ped_q <= inPedestrian;
            r_state <= w_next;

            if (w_exit) begin
                r_prescale <= '0;
                r_ms_count <= '0;
            end else if (w_tick) begin
                r_prescale <= '0;
                r_ms_count <= r_ms_count + c_ms_w'(1);
            end else begin
                r_prescale <= r_prescale + c_presc_w'(1);
            end

            if (w_exit && (w_next == S_WALK)) begin
                r_pending <= 1'b0;
            end else if (w_rise && (r_state != S_WALK)) begin
                r_pending <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
